// File: rtl/data_memory_responder_if.sv
// Data-memory bus between the CPU (master) and the memory responder (slave).
interface data_memory_responder_if;
    logic [3:0]  READ;        // [3] load enable, [2:0] funct3
    logic [2:0]  WRITE;       // [2] store enable, [1:0] funct3[1:0]
    logic [31:0] ADDR;        // byte address
    logic [31:0] WRITE_DATA;  // store data, lane-aligned from bit 0
    logic [31:0] READ_DATA;   // extended load result
    logic        BUSYWAIT;    // CPU must stall while high
    logic        MISALIGNED;  // one-cycle pulse on completion of a misaligned access

    modport master (
        output READ, WRITE, ADDR, WRITE_DATA,
        input  READ_DATA, BUSYWAIT, MISALIGNED
    );

    modport slave (
        input  READ, WRITE, ADDR, WRITE_DATA,
        output READ_DATA, BUSYWAIT, MISALIGNED
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: fixed-latency word SRAM with byte/halfword lanes,
// load sign/zero extension and misalignment reporting.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    data_memory_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                state;
    logic [CW-1:0]         counter;
    logic                  lat_store;
    logic [2:0]            lat_f3;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [31:0]           read_data_q;
    logic                  misaligned_q;

    logic [31:0]           mem [DEPTH];

    logic                  req;
    logic                  do_access;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_off;
    logic [31:0]           mem_word;
    logic [31:0]           load_data;
    logic [31:0]           store_data;
    logic [3:0]            byte_en;
    logic                  misaligned;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    // Address bits above the array are deliberately dropped (aliasing wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ADDR[31:ADDR_WIDTH+2];

    assign req       = bus.READ[3] | bus.WRITE[2];
    assign do_access = (state == BUSY) && (counter == '0);
    assign word_idx  = lat_addr[ADDR_WIDTH+1:2];
    assign byte_off  = lat_addr[1:0];
    assign mem_word  = mem[word_idx];

    // Stall in the request cycle itself and throughout BUSY; reset forces it low.
    assign bus.BUSYWAIT   = !RESET && ((state == BUSY) || ((state == IDLE) && req));
    assign bus.READ_DATA  = read_data_q;
    assign bus.MISALIGNED = misaligned_q;

    // Lane selection, extension, byte enables and misalignment for the latched access.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        byte_sel   = mem_word[{byte_off, 3'b000} +: 8];
        half_sel   = lat_addr[1] ? mem_word[31:16] : mem_word[15:0];
        load_data  = mem_word;
        store_data = lat_wdata;
        byte_en    = 4'b1111;
        misaligned = 1'b0;

        case (lat_f3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_word;
        endcase

        case (lat_f3[1:0])
            2'b00: begin
                store_data = {4{lat_wdata[7:0]}};
                byte_en    = 4'b0001 << byte_off;
            end
            2'b01: begin
                store_data = {2{lat_wdata[15:0]}};
                byte_en    = lat_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = lat_wdata;
                byte_en    = 4'b1111;
            end
        endcase

        if (lat_store) begin
            misaligned = ((lat_f3[1:0] == 2'b01) && byte_off[0]) ||
                         (lat_f3[1] && (byte_off != 2'b00));
        end else begin
            misaligned = (((lat_f3 == 3'b001) || (lat_f3 == 3'b101)) && byte_off[0]) ||
                         ((lat_f3 == 3'b010) && (byte_off != 2'b00));
        end
    end

    // Access FSM: latch the request, count down the latency, complete, then hand back.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            counter      <= '0;
            lat_store    <= 1'b0;
            lat_f3       <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            read_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            case (state)
                IDLE: begin
                    misaligned_q <= 1'b0;
                    if (req) begin
                        lat_store <= bus.WRITE[2];
                        lat_f3    <= bus.WRITE[2] ? {1'b0, bus.WRITE[1:0]} : bus.READ[2:0];
                        lat_addr  <= bus.ADDR[ADDR_WIDTH+1:0];
                        lat_wdata <= bus.WRITE_DATA;
                        counter   <= CW'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter == '0) begin
                        if (!lat_store) begin
                            read_data_q <= load_data;
                        end
                        misaligned_q <= misaligned;
                        state        <= DONE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                DONE: begin
                    misaligned_q <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store write port; the array has no reset and keeps its contents across RESET.
    always_ff @(posedge CLK) begin
        // NOTE: the memory array is intentionally not reset; only control state is.
        if (do_access && lat_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: table of accesses with a
// scoreboard of expected completions, plus hold-through-DONE and reset-abort sequences.
module tb_data_memory_responder;

    localparam int LAT = 3;

    typedef struct {
        bit          st;       // store
        bit          both;     // also raise the load enable
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;   // ignored for stores (previous value expected)
        bit          exp_mis;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        bit          mis;
        string       name;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;

    data_memory_responder_if bus_if();

    data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if.slave)
    );

    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    vec_t        vecs[$];
    logic [31:0] last_rd  = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit st, input bit both, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input bit exp_mis, input string name);
        vec_t v;
        v.st = st; v.both = both; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.name = name;
        return v;
    endfunction

    task automatic clear_req();
        bus_if.READ       = 4'h0;
        bus_if.WRITE      = 3'h0;
        bus_if.ADDR       = 32'h0;
        bus_if.WRITE_DATA = 32'h0;
    endtask

    task automatic drive(input vec_t v);
        bus_if.ADDR       = v.addr;
        bus_if.WRITE_DATA = v.wd;
        if (v.st) begin
            bus_if.WRITE = {1'b1, v.f3[1:0]};
            bus_if.READ  = v.both ? 4'b1010 : 4'h0;
        end else begin
            bus_if.READ  = {1'b1, v.f3};
            bus_if.WRITE = 3'h0;
        end
    endtask

    // One complete access; with hold=1 the request stays on the bus through DONE.
    task automatic run_vec(input vec_t v, input bit hold);
        exp_t e;
        int   cnt;
        bit   got;
        @(negedge CLK);
        drive(v);
        #1;
        check({v.name, "_busy_comb"}, {31'h0, bus_if.BUSYWAIT}, 32'h1);
        e.rd   = v.st ? last_rd : v.exp_rd;
        e.mis  = v.exp_mis;
        e.name = v.name;
        if (!v.st) last_rd = v.exp_rd;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (!hold) clear_req();
        cnt = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!bus_if.BUSYWAIT) begin
                got = 1;
                break;
            end
            cnt++;
            check({v.name, "_mis_busy"}, {31'h0, bus_if.MISALIGNED}, 32'h0);
        end
        check({v.name, "_done_seen"}, {31'h0, got}, 32'h1);
        check({v.name, "_latency"}, cnt, LAT);
        check({v.name, "_sb_nonempty"}, {31'h0, (sb.size() != 0)}, 32'h1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, "_rdata"}, bus_if.READ_DATA, e.rd);
            check({e.name, "_mis"}, {31'h0, bus_if.MISALIGNED}, {31'h0, e.mis});
        end
        if (hold) begin
            @(posedge CLK);
            #1 clear_req();
        end
        @(negedge CLK);
        check({v.name, "_mis_after"}, {31'h0, bus_if.MISALIGNED}, 32'h0);
        check({v.name, "_idle_after"}, {31'h0, bus_if.BUSYWAIT}, 32'h0);
    endtask

    initial begin
        clear_req();
        RESET = 1'b1;

        //         st both f3      addr                wd            exp_rd        mis name
        vecs.push_back(mk(1, 0, 3'b010, 32'h10,          32'hDEADBEEF, 32'h0,        0, "sw_10"));
        vecs.push_back(mk(0, 0, 3'b010, 32'h10,          32'h0,        32'hDEADBEEF, 0, "lw_10"));
        vecs.push_back(mk(1, 0, 3'b010, 32'h20,          32'h0,        32'h0,        0, "sw_20_zero"));
        vecs.push_back(mk(1, 0, 3'b000, 32'h21,          32'h80,       32'h0,        0, "sb_21"));
        vecs.push_back(mk(0, 0, 3'b000, 32'h21,          32'h0,        32'hFFFFFF80, 0, "lb_21"));
        vecs.push_back(mk(0, 0, 3'b100, 32'h21,          32'h0,        32'h00000080, 0, "lbu_21"));
        vecs.push_back(mk(0, 0, 3'b010, 32'h20,          32'h0,        32'h00008000, 0, "lw_20"));
        vecs.push_back(mk(1, 0, 3'b001, 32'h32,          32'h1234,     32'h0,        0, "sh_32"));
        vecs.push_back(mk(0, 0, 3'b001, 32'h32,          32'h0,        32'h00001234, 0, "lh_32"));
        vecs.push_back(mk(1, 0, 3'b001, 32'h30,          32'h8001,     32'h0,        0, "sh_30"));
        vecs.push_back(mk(0, 0, 3'b101, 32'h30,          32'h0,        32'h00008001, 0, "lhu_30"));
        vecs.push_back(mk(0, 0, 3'b001, 32'h30,          32'h0,        32'hFFFF8001, 0, "lh_30"));
        vecs.push_back(mk(0, 0, 3'b010, 32'h30,          32'h0,        32'h12348001, 0, "lw_30"));
        vecs.push_back(mk(0, 0, 3'b010, 32'h13,          32'h0,        32'hDEADBEEF, 1, "lw_13_mis"));
        vecs.push_back(mk(0, 0, 3'b010, 32'h10 + 4096,   32'h0,        32'hDEADBEEF, 0, "lw_alias"));
        vecs.push_back(mk(0, 0, 3'b001, 32'h31,          32'h0,        32'hFFFF8001, 1, "lh_31_mis"));
        vecs.push_back(mk(1, 0, 3'b000, 32'h12,          32'hFFFFFFAB, 32'h0,        0, "sb_12"));
        vecs.push_back(mk(0, 0, 3'b010, 32'h10,          32'h0,        32'hDEABBEEF, 0, "lw_10_sb"));
        vecs.push_back(mk(1, 0, 3'b001, 32'h33,          32'hBEEF,     32'h0,        1, "sh_33_mis"));
        vecs.push_back(mk(0, 0, 3'b010, 32'h30,          32'h0,        32'hBEEF8001, 0, "lw_30_mis"));
        vecs.push_back(mk(0, 0, 3'b101, 32'h32,          32'h0,        32'h0000BEEF, 0, "lhu_32"));
        vecs.push_back(mk(1, 0, 3'b011, 32'h50,          32'h11223344, 32'h0,        0, "sw11_50"));
        vecs.push_back(mk(0, 0, 3'b011, 32'h50,          32'h0,        32'h11223344, 0, "lundef_50"));
        vecs.push_back(mk(1, 1, 3'b010, 32'h60,          32'h00000077, 32'h0,        0, "rw_both_60"));
        vecs.push_back(mk(0, 0, 3'b010, 32'h60,          32'h0,        32'h00000077, 0, "lw_60"));

        repeat (2) @(negedge CLK);
        check("rst_rdata", bus_if.READ_DATA, 32'h0);
        check("rst_busy", {31'h0, bus_if.BUSYWAIT}, 32'h0);
        check("rst_mis", {31'h0, bus_if.MISALIGNED}, 32'h0);
        RESET = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], 1'b0);

        // Request held through DONE must not start a second access.
        run_vec(mk(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEABBEEF, 0, "lw_hold"), 1'b1);

        // Reset in BUSY cycle 1 aborts the store; old word survives.
        run_vec(mk(1, 0, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0, "sw_40_old"), 1'b0);
        run_vec(mk(0, 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, "lw_40_pre"), 1'b0);
        @(negedge CLK);
        drive(mk(1, 0, 3'b010, 32'h40, 32'h55, 32'h0, 0, "sw_40_abort"));
        @(posedge CLK);
        #1 clear_req();
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("abort_busy", {31'h0, bus_if.BUSYWAIT}, 32'h0);
        check("abort_rdata", bus_if.READ_DATA, 32'h0);
        check("abort_mis", {31'h0, bus_if.MISALIGNED}, 32'h0);
        last_rd = 32'h0;
        repeat (2) @(negedge CLK);
        check("abort_busy_held", {31'h0, bus_if.BUSYWAIT}, 32'h0);
        RESET = 1'b0;
        run_vec(mk(0, 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, "lw_40_post"), 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
